// File: rtl/rom_port_arbiter.sv
// Arbitrates the shared instruction-ROM read port between fetch (IF) and load (LD) requesters.
// Optional macro ROM_ARB_RR_EN switches contention from fixed LD>IF priority to round-robin.
`ifndef ROM_ADDRESS_BITWIDTH
`define ROM_ADDRESS_BITWIDTH 16
`endif

module rom_port_arbiter #(
  parameter int unsigned ADDR_W = `ROM_ADDRESS_BITWIDTH,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  input  logic              if_flush,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  input  logic              ld_req_valid,
  input  logic [ADDR_W-1:0] ld_req_addr,
  output logic              ld_req_ready,
  output logic              ld_resp_valid,
  output logic [DATA_W-1:0] ld_resp_data,
  output logic              ld_resp_err,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2
  } owner_t;

  owner_t            pend_q, pend_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] hold_q, hold_d;
  logic [ADDR_W-1:0] if_word_addr, ld_word_addr;
  logic              gnt_if, gnt_ld;
`ifdef ROM_ARB_RR_EN
  logic              last_ld_q, last_ld_d;  // 1: last grant went to LD, 0: to IF
`endif

  assign if_word_addr = {if_req_addr[ADDR_W-1:2], 2'b00};
  assign ld_word_addr = {ld_req_addr[ADDR_W-1:2], 2'b00};

  // State registers: owner of the in-flight read, its error flag, held address.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q    <= OWN_NONE;
      err_q     <= 1'b0;
      hold_q    <= '0;
`ifdef ROM_ARB_RR_EN
      last_ld_q <= 1'b0;
`endif
    end else begin
      pend_q    <= pend_d;
      err_q     <= err_d;
      hold_q    <= hold_d;
`ifdef ROM_ARB_RR_EN
      last_ld_q <= last_ld_d;
`endif
    end
  end

  // Grant selection and next-state for the owner/error/hold registers.
  always_comb begin
    gnt_if    = 1'b0;
    gnt_ld    = 1'b0;
    pend_d    = OWN_NONE;
    err_d     = 1'b0;
    hold_d    = hold_q;
`ifdef ROM_ARB_RR_EN
    last_ld_d = last_ld_q;
`endif

    if (!reset) begin
`ifdef ROM_ARB_RR_EN
      if (ld_req_valid && if_req_valid) begin
        gnt_ld = !last_ld_q;
        gnt_if = last_ld_q;
      end else begin
        gnt_ld = ld_req_valid;
        gnt_if = if_req_valid;
      end
`else
      gnt_ld = ld_req_valid;
      gnt_if = if_req_valid && !ld_req_valid;
`endif
    end

    if (gnt_ld) begin
      pend_d = OWN_LD;
      err_d  = |ld_req_addr[1:0];
      hold_d = ld_word_addr;
`ifdef ROM_ARB_RR_EN
      last_ld_d = 1'b1;
`endif
    end else if (gnt_if) begin
      // A flushed fetch still reads the ROM; only its response is dropped.
      pend_d = if_flush ? OWN_NONE : OWN_IF;
      hold_d = if_word_addr;
`ifdef ROM_ARB_RR_EN
      last_ld_d = 1'b0;
`endif
    end
  end

  assign if_req_ready = gnt_if;
  assign ld_req_ready = gnt_ld;

  assign rom_address = gnt_ld ? ld_word_addr :
                       gnt_if ? if_word_addr : hold_q;

  // Responses are suppressed during the reset cycle so an in-flight read is dropped.
  assign if_resp_valid = !reset && (pend_q == OWN_IF);
  assign ld_resp_valid = !reset && (pend_q == OWN_LD);
  assign ld_resp_err   = ld_resp_valid && err_q;
  assign if_resp_data  = rom_data;
  assign ld_resp_data  = rom_data;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed vector table plus randomized traffic against a reference model.
module tb_rom_port_arbiter;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req_valid, if_req_ready, if_flush, if_resp_valid;
  logic [AW-1:0] if_req_addr;
  logic [DW-1:0] if_resp_data;
  logic          ld_req_valid, ld_req_ready, ld_resp_valid, ld_resp_err;
  logic [AW-1:0] ld_req_addr;
  logic [DW-1:0] ld_resp_data;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_data;
  logic [AW-1:0] rom_q;

  always #5 clk = ~clk;

  rom_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_ready(ld_req_ready),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data), .ld_resp_err(ld_resp_err),
    .rom_address(rom_address), .rom_data(rom_data)
  );

  function automatic logic [31:0] romw(input int i);
    return 32'h5A00_0000 + 32'(i);
  endfunction

  // Synchronous-read ROM: registers the address, word i holds romw(i).
  always_ff @(posedge clk) rom_q <= rom_address;
  assign rom_data = romw(int'(rom_q[AW-1:2]));

  typedef struct {
    bit rst; bit ifv; int ifa; bit fl; bit ldv; int lda;
    bit ifr; bit ldr; int rom; bit ifrv; bit ldrv; bit err; int wd;
  } vec_t;

  vec_t tv[26];
  int   vec_cnt = 0;
  int   mis_cnt = 0;

  // Reference model state: response due next cycle, held address, last grant (1=IF, 2=LD).
  int m_pend = 0;
  int m_paddr = 0;
  bit m_perr = 1'b0;
  int m_hold = 0;
  bit m_hold_known = 1'b0;
  int m_last = 1;

  function automatic vec_t mk(bit rst, bit ifv, int ifa, bit fl, bit ldv, int lda,
                              bit ifr, bit ldr, int rom, bit ifrv, bit ldrv, bit err, int wd);
    vec_t v;
    v.rst = rst; v.ifv = ifv; v.ifa = ifa; v.fl = fl; v.ldv = ldv; v.lda = lda;
    v.ifr = ifr; v.ldr = ldr; v.rom = rom; v.ifrv = ifrv; v.ldrv = ldrv; v.err = err; v.wd = wd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit ifv, input int ifa, input bit fl,
                       input bit ldv, input int lda);
    reset        = rst;
    if_req_valid = ifv;
    if_req_addr  = AW'(ifa);
    if_flush     = fl;
    ld_req_valid = ldv;
    ld_req_addr  = AW'(lda);
  endtask

  // Compare all outputs against the model for the current cycle, then advance the model.
  task automatic model_step(output int g);
    int ga, ta;
    bit eif, eld;
    g = 0;
    if (!reset) begin
      if (ld_req_valid && if_req_valid) begin
`ifdef ROM_ARB_RR_EN
        g = (m_last == 1) ? 2 : 1;
`else
        g = 2;
`endif
      end else if (ld_req_valid) g = 2;
      else if (if_req_valid) g = 1;
    end
    ga = (g == 2) ? int'(ld_req_addr) : int'(if_req_addr);
    ta = (ga / 4) * 4;
    chk("m_if_ready", 32'(if_req_ready), 32'(g == 1));
    chk("m_ld_ready", 32'(ld_req_ready), 32'(g == 2));
    if (g != 0) chk("m_rom_address", 32'(rom_address), 32'(ta));
    else if (m_hold_known) chk("m_rom_hold", 32'(rom_address), 32'(m_hold));
    eif = !reset && (m_pend == 1);
    eld = !reset && (m_pend == 2);
    chk("m_if_resp_valid", 32'(if_resp_valid), 32'(eif));
    chk("m_ld_resp_valid", 32'(ld_resp_valid), 32'(eld));
    if (eif) chk("m_if_resp_data", if_resp_data, romw(m_paddr / 4));
    if (eld) begin
      chk("m_ld_resp_data", ld_resp_data, romw(m_paddr / 4));
      chk("m_ld_resp_err", 32'(ld_resp_err), 32'(m_perr));
    end
    if (reset) begin
      m_pend = 0; m_hold = 0; m_hold_known = 1'b1; m_last = 1;
    end else if (g != 0) begin
      m_hold = ta; m_hold_known = 1'b1; m_last = g; m_paddr = ta;
      m_perr = (g == 2) && (ga % 4 != 0);
      m_pend = (g == 2) ? 2 : (if_flush ? 0 : 1);
    end else begin
      m_pend = 0;
    end
  endtask

  bit            hold_if, hold_ld;
  bit            r_rst, r_ifv, r_ldv, r_fl;
  logic [AW-1:0] r_ifa, r_lda;

  initial begin
    int g;
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 0);

    //         rst ifv ifa  fl ldv lda    ifr ldr rom  ifrv ldrv err wd
    tv[0]  = mk(1, 0, 0,    0, 0, 0,      0, 0, -1,   0, 0, 0, -1);
    tv[1]  = mk(1, 0, 0,    0, 0, 0,      0, 0, 0,    0, 0, 0, -1);
    tv[2]  = mk(0, 1, 'h0,  0, 0, 0,      1, 0, 'h0,  0, 0, 0, -1);
    tv[3]  = mk(0, 1, 'h4,  0, 0, 0,      1, 0, 'h4,  1, 0, 0, 0);
    tv[4]  = mk(0, 1, 'h8,  0, 0, 0,      1, 0, 'h8,  1, 0, 0, 1);
    tv[5]  = mk(0, 0, 0,    0, 0, 0,      0, 0, 'h8,  1, 0, 0, 2);
    tv[6]  = mk(0, 0, 0,    0, 0, 0,      0, 0, 'h8,  0, 0, 0, -1);
`ifdef ROM_ARB_RR_EN
    tv[7]  = mk(0, 1, 'h10, 0, 1, 'h20,   0, 1, 'h20, 0, 0, 0, -1);
    tv[8]  = mk(0, 1, 'h10, 0, 1, 'h20,   1, 0, 'h10, 0, 1, 0, 8);
    tv[9]  = mk(0, 1, 'h10, 0, 1, 'h20,   0, 1, 'h20, 1, 0, 0, 4);
    tv[10] = mk(0, 1, 'h10, 0, 1, 'h20,   1, 0, 'h10, 0, 1, 0, 8);
    tv[11] = mk(0, 0, 0,    0, 0, 0,      0, 0, 'h10, 1, 0, 0, 4);
`else
    tv[7]  = mk(0, 1, 'h10, 0, 1, 'h20,   0, 1, 'h20, 0, 0, 0, -1);
    tv[8]  = mk(0, 1, 'h10, 0, 1, 'h20,   0, 1, 'h20, 0, 1, 0, 8);
    tv[9]  = mk(0, 1, 'h10, 0, 1, 'h20,   0, 1, 'h20, 0, 1, 0, 8);
    tv[10] = mk(0, 1, 'h10, 0, 1, 'h20,   0, 1, 'h20, 0, 1, 0, 8);
    tv[11] = mk(0, 0, 0,    0, 0, 0,      0, 0, 'h20, 0, 1, 0, 8);
`endif
    tv[12] = mk(0, 1, 'hC,  1, 0, 0,      1, 0, 'hC,  0, 0, 0, -1);
    tv[13] = mk(0, 0, 0,    0, 0, 0,      0, 0, 'hC,  0, 0, 0, -1);
    tv[14] = mk(0, 0, 0,    1, 1, 'hC,    0, 1, 'hC,  0, 0, 0, -1);
    tv[15] = mk(0, 0, 0,    0, 0, 0,      0, 0, 'hC,  0, 1, 0, 3);
    tv[16] = mk(0, 0, 0,    0, 1, 'h22,   0, 1, 'h20, 0, 0, 0, -1);
    tv[17] = mk(0, 0, 0,    0, 1, 'h24,   0, 1, 'h24, 0, 1, 1, 8);
    tv[18] = mk(0, 0, 0,    0, 0, 0,      0, 0, 'h24, 0, 1, 0, 9);
    tv[19] = mk(0, 1, 'h8,  0, 0, 0,      1, 0, 'h8,  0, 0, 0, -1);
    tv[20] = mk(1, 1, 'h10, 0, 0, 0,      0, 0, 'h8,  0, 0, 0, -1);
    tv[21] = mk(0, 0, 0,    0, 0, 0,      0, 0, 0,    0, 0, 0, -1);
    tv[22] = mk(0, 0, 0,    0, 1, 'h30,   0, 1, 'h30, 0, 0, 0, -1);
    tv[23] = mk(0, 0, 0,    0, 0, 0,      0, 0, 'h30, 0, 1, 0, 12);
    tv[24] = mk(0, 0, 0,    0, 0, 0,      0, 0, 'h30, 0, 0, 0, -1);
    tv[25] = mk(0, 0, 0,    0, 0, 0,      0, 0, 'h30, 0, 0, 0, -1);

    for (int i = 0; i < 26; i++) begin
      @(posedge clk); #1;
      drive(tv[i].rst, tv[i].ifv, tv[i].ifa, tv[i].fl, tv[i].ldv, tv[i].lda);
      #4;
      chk($sformatf("t%0d_if_ready", i), 32'(if_req_ready), 32'(tv[i].ifr));
      chk($sformatf("t%0d_ld_ready", i), 32'(ld_req_ready), 32'(tv[i].ldr));
      if (tv[i].rom >= 0) chk($sformatf("t%0d_rom_address", i), 32'(rom_address), 32'(tv[i].rom));
      chk($sformatf("t%0d_if_resp_valid", i), 32'(if_resp_valid), 32'(tv[i].ifrv));
      chk($sformatf("t%0d_ld_resp_valid", i), 32'(ld_resp_valid), 32'(tv[i].ldrv));
      if (tv[i].wd >= 0) begin
        if (tv[i].ifrv) chk($sformatf("t%0d_if_resp_data", i), if_resp_data, romw(tv[i].wd));
        else chk($sformatf("t%0d_ld_resp_data", i), ld_resp_data, romw(tv[i].wd));
      end
      if (tv[i].ldrv) chk($sformatf("t%0d_ld_resp_err", i), 32'(ld_resp_err), 32'(tv[i].err));
      model_step(g);
    end

    // Random traffic; an ungranted requester keeps valid and addr stable.
    hold_if = 1'b0;
    hold_ld = 1'b0;
    r_ifa = '0;
    r_lda = '0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      r_rst = ($urandom_range(63) == 0);
      r_fl  = ($urandom_range(3) == 0);
      r_ifv = hold_if ? 1'b1 : ($urandom_range(3) != 0);
      r_ldv = hold_ld ? 1'b1 : ($urandom_range(2) == 0);
      if (!hold_if) r_ifa = AW'($urandom_range(1023));
      if (!hold_ld) r_lda = AW'($urandom_range(1023));
      drive(r_rst, r_ifv, int'(r_ifa), r_fl, r_ldv, int'(r_lda));
      #4;
      model_step(g);
      hold_if = r_ifv && (g != 1);
      hold_ld = r_ldv && (g != 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end
endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single synchronous-read instruction ROM port between two requesters: instruction fetch (IF) and data load (LD, for constants placed in ROM).
- Accepts word reads from both requesters and grants at most one per cycle.
- Drives the ROM byte address. The ROM registers the address, so data is read one cycle later.
- Returns data to the owner of the read, tagged by which response port fires.

Parameters:
- ADDR_W, `ROM_ADDRESS_BITWIDTH, byte-address width of the ROM and of both request ports.
- DATA_W, 32, ROM word width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req_valid  in  1  fetch request present.
- if_req_addr  in  ADDR_W  fetch byte address.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_flush  in  1  discard any fetch response due next cycle (branch redirect).
- if_resp_valid  out  1  fetch data valid.
- if_resp_data  out  DATA_W  fetch word.
- ld_req_valid  in  1  load request present.
- ld_req_addr  in  ADDR_W  load byte address.
- ld_req_ready  out  1  load request accepted this cycle.
- ld_resp_valid  out  1  load data valid.
- ld_resp_data  out  DATA_W  load word.
- ld_resp_err  out  1  load address misaligned; qualifies ld_resp_valid.
- rom_address  out  ADDR_W  to ROM address input.
- rom_data  in  DATA_W  from ROM data output.

Behaviour:
- Request handshake:
  - A request transfers in the cycle where valid and ready are both 1.
  - Ready is combinational from this cycle's valids and the arbitration state. There is no request queue.
  - At most one ready is high per cycle.
  - An ungranted requester must hold valid and addr stable.
- Arbitration (default, no macro):
  - Fixed priority, LD over IF.
  - If only one requester is valid, it is granted.
  - If neither is valid, no grant is made and rom_address holds its last driven value (registered copy, 0 after reset).
- rom_address: combinational mux of the granted addr. With no grant it shows the hold register. It is never X.
- Latency:
  - Grant in cycle N: the ROM samples rom_address at the end of N.
  - Cycle N+1: the owner's resp_valid=1 and resp_data=rom_data. Exactly one cycle, fixed.
  - Back-to-back grants every cycle give full throughput.
- Owner register:
  - 2-bit pend_owner ∈ {NONE, IF, LD}, loaded each cycle from this cycle's grant.
  - resp_valid for a port equals (pend_owner == that port).
- Responses have no backpressure. Consumers must take the data in the response cycle.
- Flush:
  - if_flush=1 in cycle N, with an IF grant in N, forces pend_owner=NONE for N+1, so no if_resp_valid.
  - if_flush does not block an IF grant in the same cycle, but that grant is discarded.
  - An LD response is never affected by flush.
- Alignment:
  - An LD grant with ld_req_addr[1:0]≠0 still reads the ROM at the word-truncated address.
  - ld_resp_err=1 alongside ld_resp_valid in the response cycle. Error state is held in a 1-bit register beside pend_owner.
  - IF addresses are word-truncated with no error reported.
- Reset, sampled synchronously:
  - pend_owner=NONE, hold address=0, err=0.
  - All resp_valid=0 and both readies=0 during the reset cycle.
  - Any in-flight response is dropped; no response appears in the cycle after reset deasserts.
  - resp_data outputs pass rom_data through and are don't-care when not valid.

Optional Feature:
- Macro: ROM_ARB_RR_EN.
- Defined:
  - A 1-bit last_grant register (reset value IF).
  - When both requesters are valid, grant the one not equal to last_grant. last_grant updates on every grant.
  - Sole requesters are always granted.
  - Bounds LD-induced fetch starvation to one cycle.
- Undefined: fixed LD>IF priority as above, and no last_grant register.

Test Plan:
- Reset, then IF alone reading addr 0x0,0x4,0x8 back-to-back → if_req_ready=1 each cycle; if_resp_valid in cycles 1,2,3 with rom words 0,1,2; ld_resp_valid=0 throughout.
- Both valid for 4 cycles (IF 0x10, LD 0x20), macro off → LD granted each cycle and IF ready=0; 4 ld_resp with word 8; no if_resp. Macro on → grants LD,IF,LD,IF; responses alternate word 8 and word 4.
- IF granted at 0x0C with if_flush=1 same cycle → no if_resp_valid next cycle. LD granted at 0x0C with if_flush=1 → ld_resp_valid=1 with word 3.
- LD at 0x22 → next cycle ld_resp_valid=1, ld_resp_err=1, data=word 8. LD at 0x24 → err=0.
- IF granted at 0x08, reset asserted next cycle → no if_resp_valid in the reset cycle or the first post-reset cycle; rom_address=0 after reset with no request.
- No requests for 3 cycles after an LD to 0x30 → rom_address holds 0x30; both resp_valid=0.
